dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU load/store path (port A) and a debug/loader port (port B) used to preload or inspect memory while the CPU runs.
- Sits between the IO controller's data-memory outputs and the data-memory controller.
- Performs round-robin arbitration with optional locked bursts, range checking and 1-cycle read-data return.

Parameters:
- DBITS, 32, data and address width
- DMEMADDRBITS, 13, byte-address bits decoded into data memory
- DMEMWORDBITS, 2, byte-offset bits dropped to form the word index
- MAX_BURST, 8, maximum consecutive locked grants to one port while the other is requesting (range 1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- a_req  in  1  port A request; held until a_gnt
- a_we  in  1  port A write enable
- a_lock  in  1  port A asks to keep ownership after this grant
- a_addr  in  DBITS  port A byte address
- a_wdata  in  DBITS  port A write data
- a_gnt  out  1  port A transaction accepted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DBITS  port A read data
- a_err  out  1  port A out-of-range access, pulses with the response
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  same as port A, for port B
- mem_wrtEn  out  1  data-memory write enable
- mem_index  out  DMEMADDRBITS-DMEMWORDBITS  word index
- mem_dataIn  out  DBITS  data-memory write data
- mem_dataOut  in  DBITS  data-memory read data, valid the cycle after the index is presented

Behaviour:
- Reset: every output is 0 (all gnt/rvalid/err/rdata, mem_wrtEn, mem_index, mem_dataIn). FSM goes to IDLE, round-robin pointer is set to prefer A, burst counter is 0. Reset in mid-burst drops ownership. A pending read response is discarded.
- FSM states:
  - IDLE: no owner.
  - OWN_A: A holds a lock.
  - OWN_B: B holds a lock.
- gnt is combinational from state, pointer and req. At most one gnt per cycle.
- Arbitration in IDLE:
  - Only one request: that port is granted.
  - Both request: the pointer's port is granted; the pointer then flips to the other port.
- Lock and bursts:
  - A granted port with lock=1 moves the FSM to OWN_x and the burst counter is set to 1.
  - In OWN_x only port x can be granted. The other port waits even if x is idle.
  - Each grant to x while the other port is requesting increments the counter.
  - Return to IDLE when x is granted with lock=0, or when x drops req with lock=0.
  - Forced return to IDLE when the counter reaches MAX_BURST while the other port requests; the pointer then favours the other port.
- Granted cycle (cycle N):
  - mem_index = addr[DMEMADDRBITS-1:DMEMWORDBITS].
  - mem_dataIn = wdata.
  - mem_wrtEn = we & in_range.
  - in_range means addr[DBITS-1:DMEMADDRBITS]==0.
  - Write outputs are combinational; memory captures the write at the end of cycle N.
- Read response, cycle N+1:
  - rvalid=1 for the port granted a read in cycle N.
  - rdata = mem_dataOut, or 0 if out of range.
  - Writes generate no rvalid.
  - Back-to-back reads give one response per cycle, in grant order.
- Out of range:
  - A write is acknowledged (gnt) but memory is not written; err pulses in N+1.
  - A read returns rdata=0 with rvalid=1 and err=1 in N+1.
- Read-after-write to the same index in consecutive cycles returns the new data; the memory is write-first.
- A request dropped before gnt is legal and is simply not served.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_a_grants[15:0], stat_b_grants[15:0] and stat_conflicts[15:0].
  - stat_conflicts counts cycles where both ports request.
  - All three are saturating at 16'hFFFF and clear on reset.
- DMEM_ARB_STATS_EN undefined: ports and logic are absent.

Decomposition:
- Shared package/header dmem_arb.vh holds:
  - FSM state encodings ARB_IDLE, ARB_OWN_A, ARB_OWN_B.
  - Port-ID constants PORT_A, PORT_B.
  - The default MAX_BURST.
- One sub-module: dmem_arb_rr, holding the round-robin pointer, FSM and burst counter, and producing the grant vector. The datapath muxing and response pipeline stay in the top.

Test Plan:
- A writes 32'hDEADBEEF to 32'h0000_0040, then reads the same address -> index 16; mem_wrtEn high for 1 cycle; a_rvalid with a_rdata=32'hDEADBEEF one cycle after the read grant.
- a_req and b_req held high for 6 cycles, no lock -> grants alternate A,B,A,B,A,B.
- B locks with both ports requesting continuously, MAX_BURST=4 -> B granted 4 consecutive cycles, then A granted; pointer favours A.
- A reads 32'h0000_2000 (out of range) -> a_gnt, no mem_wrtEn; next cycle a_rvalid=1, a_err=1, a_rdata=0.
- reset asserted low during a locked B burst with a read outstanding -> next cycle all outputs 0, FSM IDLE, no rvalid; A then granted first.
- Built with DMEM_ARB_STATS_EN, 10 cycles of dual requests -> stat_conflicts=10, stat_a_grants=5, stat_b_grants=5.

Source files
------------

// File: rtl/dmem_bus_arbiter_pkg.sv
// rtl/dmem_bus_arbiter_pkg.sv - shared constants for the data-memory bus arbiter
//
// Purpose : FSM state encodings, port identifiers and the default burst limit
//           shared by dmem_arb_rr and dmem_bus_arbiter.
// Ports   : none (package)
package dmem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - round-robin pointer, lock FSM and burst counter
//
// Purpose : decides which port (if any) is granted this cycle.
// Ports   : clk, reset (sync, active-low)
//           i_a_req/i_a_lock, i_b_req/i_b_lock  - requests and lock hints
//           o_gnt_a/o_gnt_b                     - combinational one-hot grant
module dmem_arb_rr
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic i_a_req,
  input  logic i_a_lock,
  input  logic i_b_req,
  input  logic i_b_lock,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  localparam logic [7:0] LP_MAX = 8'(MAX_BURST);

  arb_state_t r_state, w_state_nxt;
  logic       r_ptr, w_ptr_nxt;
  logic [7:0] r_burst, w_burst_nxt, w_cnt;
  logic       w_own_b, w_own_req, w_own_lock, w_oth_req;
  logic       w_win, w_win_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_ptr   <= PORT_A;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst;
    w_cnt       = r_burst;
    w_win       = 1'b0;
    w_win_b     = 1'b0;
    o_gnt_a     = 1'b0;
    o_gnt_b     = 1'b0;
    w_own_b     = (r_state == ARB_OWN_B);
    w_own_req   = w_own_b ? i_b_req  : i_a_req;
    w_own_lock  = w_own_b ? i_b_lock : i_a_lock;
    w_oth_req   = w_own_b ? i_a_req  : i_b_req;

    if (r_state == ARB_IDLE) begin
      w_burst_nxt = '0;
      if (i_a_req && i_b_req) begin
        w_win     = 1'b1;
        w_win_b   = (r_ptr == PORT_B);
        w_ptr_nxt = ~r_ptr;
      end else if (i_a_req || i_b_req) begin
        w_win   = 1'b1;
        w_win_b = i_b_req;
      end
      o_gnt_a = w_win & ~w_win_b;
      o_gnt_b = w_win & w_win_b;
      if (w_win && (w_win_b ? i_b_lock : i_a_lock)) begin
        w_burst_nxt = 8'd1;
        // A burst limit of 1 is already used up by the locking grant itself.
        if ((w_win_b ? i_a_req : i_b_req) && (LP_MAX <= 8'd1))
          w_ptr_nxt = w_win_b ? PORT_A : PORT_B;
        else
          w_state_nxt = w_win_b ? ARB_OWN_B : ARB_OWN_A;
      end
    end else begin
      if (w_oth_req && (r_burst >= LP_MAX)) begin
        w_state_nxt = ARB_IDLE;
        w_ptr_nxt   = w_own_b ? PORT_A : PORT_B;
      end else if (w_own_req) begin
        o_gnt_a     = ~w_own_b;
        o_gnt_b     = w_own_b;
        // Only grants that made the other port wait count against the burst.
        w_cnt       = w_oth_req ? (r_burst + 8'd1) : r_burst;
        w_burst_nxt = w_cnt;
        if (!w_own_lock) begin
          w_state_nxt = ARB_IDLE;
        end else if (w_oth_req && (w_cnt >= LP_MAX)) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = w_own_b ? PORT_A : PORT_B;
        end
      end else if (!w_own_lock) begin
        w_state_nxt = ARB_IDLE;
      end
    end

    // Outputs read as zero for the whole time reset is held.
    if (!reset) begin
      o_gnt_a = 1'b0;
      o_gnt_b = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - two-port round-robin arbiter in front of data memory
//
// Purpose : shares one data-memory port between the CPU (A) and a debug/loader
//           port (B); muxes the granted request onto memory and returns read
//           data one cycle after the grant.
// Ports   : clk, reset (sync, active-low)
//           a_* / b_*    - req, we, lock, addr, wdata in; gnt, rvalid, rdata, err out
//           mem_wrtEn, mem_index, mem_dataIn - memory request (combinational)
//           mem_dataOut  - memory read data, valid the cycle after the index
//           stat_*       - grant/conflict counters, only with DMEM_ARB_STATS_EN
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int DMEMADDRBITS = 13,
  parameter int DMEMWORDBITS = 2,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             a_req,
  input  logic                             a_we,
  input  logic                             a_lock,
  input  logic [DBITS-1:0]                 a_addr,
  input  logic [DBITS-1:0]                 a_wdata,
  output logic                             a_gnt,
  output logic                             a_rvalid,
  output logic [DBITS-1:0]                 a_rdata,
  output logic                             a_err,
  input  logic                             b_req,
  input  logic                             b_we,
  input  logic                             b_lock,
  input  logic [DBITS-1:0]                 b_addr,
  input  logic [DBITS-1:0]                 b_wdata,
  output logic                             b_gnt,
  output logic                             b_rvalid,
  output logic [DBITS-1:0]                 b_rdata,
  output logic                             b_err,
  output logic                             mem_wrtEn,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_index,
  output logic [DBITS-1:0]                 mem_dataIn,
  input  logic [DBITS-1:0]                 mem_dataOut
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]                      stat_a_grants,
  output logic [15:0]                      stat_b_grants,
  output logic [15:0]                      stat_conflicts
`endif
);

  logic             w_gnt_a, w_gnt_b, w_any_gnt;
  logic             w_we, w_in_range;
  logic [DBITS-1:0] w_addr, w_wdata;
  logic             w_unused;
  logic             r_rsp_a, r_rsp_b, r_err_a, r_err_b, r_rd_ok;

  dmem_arb_rr #(
    .MAX_BURST (MAX_BURST)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_a_req  (a_req),
    .i_a_lock (a_lock),
    .i_b_req  (b_req),
    .i_b_lock (b_lock),
    .o_gnt_a  (w_gnt_a),
    .o_gnt_b  (w_gnt_b)
  );

  assign w_any_gnt  = w_gnt_a | w_gnt_b;
  assign w_addr     = w_gnt_b ? b_addr  : a_addr;
  assign w_wdata    = w_gnt_b ? b_wdata : a_wdata;
  assign w_we       = w_gnt_b ? b_we    : a_we;
  assign w_in_range = (w_addr[DBITS-1:DMEMADDRBITS] == '0);
  assign w_unused   = ^w_addr[DMEMWORDBITS-1:0];

  assign a_gnt      = w_gnt_a;
  assign b_gnt      = w_gnt_b;
  // Memory lines idle at zero so nothing stray is presented between grants.
  assign mem_wrtEn  = w_any_gnt & w_we & w_in_range;
  assign mem_index  = w_any_gnt ? w_addr[DMEMADDRBITS-1:DMEMWORDBITS] : '0;
  assign mem_dataIn = w_any_gnt ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_a <= 1'b0;
      r_rsp_b <= 1'b0;
      r_err_a <= 1'b0;
      r_err_b <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_rsp_a <= w_gnt_a & ~a_we;
      r_rsp_b <= w_gnt_b & ~b_we;
      r_err_a <= w_gnt_a & ~w_in_range;
      r_err_b <= w_gnt_b & ~w_in_range;
      r_rd_ok <= w_any_gnt & ~w_we & w_in_range;
    end
  end

  // Gating with reset drops a response that would otherwise appear while
  // reset is being held.
  assign a_rvalid = reset & r_rsp_a;
  assign b_rvalid = reset & r_rsp_b;
  assign a_err    = reset & r_err_a;
  assign b_err    = reset & r_err_b;
  assign a_rdata  = (a_rvalid & r_rd_ok) ? mem_dataOut : '0;
  assign b_rdata  = (b_rvalid & r_rd_ok) ? mem_dataOut : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_a, r_stat_b, r_stat_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_a <= '0;
      r_stat_b <= '0;
      r_stat_c <= '0;
    end else begin
      if (w_gnt_a && (r_stat_a != 16'hFFFF)) r_stat_a <= r_stat_a + 16'd1;
      if (w_gnt_b && (r_stat_b != 16'hFFFF)) r_stat_b <= r_stat_b + 16'd1;
      if (a_req && b_req && (r_stat_c != 16'hFFFF)) r_stat_c <= r_stat_c + 16'd1;
    end
  end

  assign stat_a_grants  = r_stat_a;
  assign stat_b_grants  = r_stat_b;
  assign stat_conflicts = r_stat_c;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - self-checking bench for dmem_bus_arbiter
module tb_dmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_wrtEn;
  logic [10:0] mem_index;
  logic [31:0] mem_dataIn, mem_dataOut;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_a_grants, stat_b_grants, stat_conflicts;
`endif

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_wrtEn(mem_wrtEn), .mem_index(mem_index), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut)
`ifdef DMEM_ARB_STATS_EN
    , .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // Write-first synchronous RAM standing in for the data memory.
  logic [31:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_wrtEn) ram[mem_index] <= mem_dataIn;
    mem_dataOut <= mem_wrtEn ? mem_dataIn : ram[mem_index];
  end

  typedef struct {
    logic        rst;
    logic [2:0]  ac;   // {req, we, lock}
    logic [31:0] aa, ad;
    logic [2:0]  bc;
    logic [31:0] ba, bd;
    logic [1:0]  eg;   // {exp a_gnt, exp b_gnt}
  } vec_t;

  typedef struct {
    logic        pb;
    logic        rd;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  localparam logic [2:0] N = 3'b000, R = 3'b100, W = 3'b110, RL = 3'b101, NL = 3'b001;
  localparam logic [1:0] G0 = 2'b00, GA = 2'b10, GB = 2'b01;

  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[$];
  rsp_t        sbq[$];
  logic [31:0] shadow [int];

  function automatic vec_t mk(input logic rst, input logic [2:0] ac, input logic [31:0] aa,
                              input logic [31:0] ad, input logic [2:0] bc, input logic [31:0] ba,
                              input logic [31:0] bd, input logic [1:0] eg);
    vec_t v;
    v.rst = rst; v.ac = ac; v.aa = aa; v.ad = ad;
    v.bc = bc; v.ba = ba; v.bd = bd; v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rsp_t        e;
    logic        have, g, pb, we, inr;
    logic [31:0] addr, wd;
    int          idx;
    @(posedge clk); #1;
    reset = v.rst;
    {a_req, a_we, a_lock} = v.ac; a_addr = v.aa; a_wdata = v.ad;
    {b_req, b_we, b_lock} = v.bc; b_addr = v.ba; b_wdata = v.bd;
    @(negedge clk);
    if (!v.rst) sbq.delete();
    have = (sbq.size() > 0);
    if (have) e = sbq.pop_front();
    else e = '{pb: 1'b0, rd: 1'b0, err: 1'b0, data: 32'h0};
    chk({tag, " a_rvalid"}, 32'(a_rvalid), 32'(have && !e.pb && e.rd));
    chk({tag, " a_err"},    32'(a_err),    32'(have && !e.pb && e.err));
    chk({tag, " a_rdata"},  a_rdata,       (have && !e.pb && e.rd) ? e.data : 32'h0);
    chk({tag, " b_rvalid"}, 32'(b_rvalid), 32'(have && e.pb && e.rd));
    chk({tag, " b_err"},    32'(b_err),    32'(have && e.pb && e.err));
    chk({tag, " b_rdata"},  b_rdata,       (have && e.pb && e.rd) ? e.data : 32'h0);
    chk({tag, " a_gnt"},    32'(a_gnt),    32'(v.eg[1]));
    chk({tag, " b_gnt"},    32'(b_gnt),    32'(v.eg[0]));
    g    = (v.eg != G0);
    pb   = v.eg[0];
    we   = pb ? v.bc[1] : v.ac[1];
    addr = pb ? v.ba : v.aa;
    wd   = pb ? v.bd : v.ad;
    inr  = (addr[31:13] == 19'h0);
    idx  = int'(addr[12:2]);
    chk({tag, " mem_wrtEn"}, 32'(mem_wrtEn), 32'(g && we && inr));
    if (g) chk({tag, " mem_index"}, 32'(mem_index), 32'(addr[12:2]));
    if (g && we) chk({tag, " mem_dataIn"}, mem_dataIn, wd);
    if (!v.rst) begin
      chk({tag, " rst mem_index"},  32'(mem_index), 32'h0);
      chk({tag, " rst mem_dataIn"}, mem_dataIn,     32'h0);
    end
    if (g && v.rst) begin
      if (we && inr) shadow[idx] = wd;
      e.pb   = pb;
      e.rd   = !we;
      e.err  = !inr;
      e.data = (!we && inr) ? (shadow.exists(idx) ? shadow[idx] : 32'h0) : 32'h0;
      sbq.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b0;
    {a_req, a_we, a_lock, b_req, b_we, b_lock} = 6'b0;
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;

    // reset
    vecs.push_back(mk(1'b0, N,  32'h0,    32'h0,        N,  32'h0,    32'h0, G0));
    vecs.push_back(mk(1'b0, N,  32'h0,    32'h0,        N,  32'h0,    32'h0, G0));
    // basic write then read of the same word
    vecs.push_back(mk(1'b1, W,  32'h40,   32'hDEADBEEF, N,  32'h0,    32'h0, GA));
    vecs.push_back(mk(1'b1, R,  32'h40,   32'h0,        N,  32'h0,    32'h0, GA));
    vecs.push_back(mk(1'b1, N,  32'h0,    32'h0,        N,  32'h0,    32'h0, G0));
    // round-robin alternation, read-after-write, out-of-range write
    vecs.push_back(mk(1'b1, W,  32'h80,   32'h11111111, R,  32'h40,   32'h0, GA));
    vecs.push_back(mk(1'b1, W,  32'h84,   32'h22222222, R,  32'h80,   32'h0, GB));
    vecs.push_back(mk(1'b1, W,  32'h84,   32'h22222222, R,  32'h84,   32'h0, GA));
    vecs.push_back(mk(1'b1, R,  32'h84,   32'h0,        R,  32'h84,   32'h0, GB));
    vecs.push_back(mk(1'b1, W,  32'h2000, 32'h55555555, R,  32'h40,   32'h0, GA));
    vecs.push_back(mk(1'b1, R,  32'h80,   32'h0,        R,  32'h40,   32'h0, GB));
    // locked B burst capped at 4 while A waits
    vecs.push_back(mk(1'b1, R,  32'h80,   32'h0,        RL, 32'h40,   32'h0, GA));
    vecs.push_back(mk(1'b1, R,  32'h84,   32'h0,        RL, 32'h40,   32'h0, GB));
    vecs.push_back(mk(1'b1, R,  32'h84,   32'h0,        RL, 32'h84,   32'h0, GB));
    vecs.push_back(mk(1'b1, R,  32'h84,   32'h0,        RL, 32'h80,   32'h0, GB));
    vecs.push_back(mk(1'b1, R,  32'h84,   32'h0,        RL, 32'h40,   32'h0, GB));
    vecs.push_back(mk(1'b1, R,  32'h84,   32'h0,        RL, 32'h40,   32'h0, GA));
    vecs.push_back(mk(1'b1, N,  32'h0,    32'h0,        N,  32'h0,    32'h0, G0));
    // out-of-range read
    vecs.push_back(mk(1'b1, R,  32'h2000, 32'h0,        N,  32'h0,    32'h0, GA));
    vecs.push_back(mk(1'b1, N,  32'h0,    32'h0,        N,  32'h0,    32'h0, G0));
    // owner idle but still locked: A waits, then release by dropping lock
    vecs.push_back(mk(1'b1, N,  32'h0,    32'h0,        RL, 32'h40,   32'h0, GB));
    vecs.push_back(mk(1'b1, R,  32'h80,   32'h0,        NL, 32'h0,    32'h0, G0));
    vecs.push_back(mk(1'b1, R,  32'h80,   32'h0,        N,  32'h0,    32'h0, G0));
    vecs.push_back(mk(1'b1, R,  32'h80,   32'h0,        N,  32'h0,    32'h0, GA));
    vecs.push_back(mk(1'b1, N,  32'h0,    32'h0,        N,  32'h0,    32'h0, G0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // reset during a locked B read: response dropped, pointer back to A
    apply(mk(1'b1, N, 32'h0,  32'h0, RL, 32'h40, 32'h0, GB), "mid_lock");
    apply(mk(1'b0, R, 32'h80, 32'h0, RL, 32'h40, 32'h0, G0), "mid_rst");
    apply(mk(1'b1, R, 32'h80, 32'h0, RL, 32'h40, 32'h0, GA), "post_rst");
    apply(mk(1'b1, N, 32'h0,  32'h0, N,  32'h0,  32'h0, G0), "post_idle");

`ifdef DMEM_ARB_STATS_EN
    apply(mk(1'b0, N, 32'h0, 32'h0, N, 32'h0, 32'h0, G0), "st_rst");
    for (int i = 0; i < 10; i++)
      apply(mk(1'b1, R, 32'h40, 32'h0, R, 32'h40, 32'h0, (i % 2 == 0) ? GA : GB),
            $sformatf("st%0d", i));
    apply(mk(1'b1, N, 32'h0, 32'h0, N, 32'h0, 32'h0, G0), "st_idle");
    chk("stat_conflicts", 32'(stat_conflicts), 32'd10);
    chk("stat_a_grants",  32'(stat_a_grants),  32'd5);
    chk("stat_b_grants",  32'(stat_b_grants),  32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
